// File: rtl/draw_fade_mux.sv
// Screen compositor: picks one of N_SRC aligned VGA streams and cross-fades
// through black on a source change, switching only inside vertical blanking.
module draw_fade_mux #(
    parameter int unsigned N_SRC           = 6,
    parameter int unsigned HC_W            = 11,
    parameter int unsigned RGB_W           = 12,
    parameter int unsigned FADE_SHIFT      = 3,
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter logic [RGB_W-1:0] DEFAULT_RGB = 12'h0F0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(N_SRC+1)-1:0]   sel,
    input  logic [N_SRC*HC_W-1:0]        src_hcount,
    input  logic [N_SRC*HC_W-1:0]        src_vcount,
    input  logic [N_SRC-1:0]             src_hblnk,
    input  logic [N_SRC-1:0]             src_vblnk,
    input  logic [N_SRC-1:0]             src_hsync,
    input  logic [N_SRC-1:0]             src_vsync,
    input  logic [N_SRC*RGB_W-1:0]       src_rgb,
    output logic [HC_W-1:0]              out_hcount,
    output logic [HC_W-1:0]              out_vcount,
    output logic                         out_hblnk,
    output logic                         out_vblnk,
    output logic                         out_hsync,
    output logic                         out_vsync,
    output logic [RGB_W-1:0]             out_rgb,
    output logic [$clog2(N_SRC+1)-1:0]   active_src,
    output logic                         fading
);

    localparam int unsigned SEL_W = $clog2(N_SRC + 1);
    localparam int unsigned LVL_W = FADE_SHIFT + 1;
    localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned CH_N  = RGB_W / 4;
    localparam int unsigned MUL_W = 4 + FADE_SHIFT + 1;
    localparam logic [LVL_W-1:0] FULL     = LVL_W'(2 ** FADE_SHIFT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN} state_t;

    state_t            state;
    logic [SEL_W-1:0]  pending;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  step_cnt;

    logic [HC_W-1:0]   s1_hcount, s1_vcount;
    logic              s1_hblnk, s1_vblnk, s1_hsync, s1_vsync, s1_vblnk_d;
    logic [RGB_W-1:0]  s1_rgb;

    logic [HC_W-1:0]   mux_hcount_c, mux_vcount_c;
    logic              mux_hblnk_c, mux_vblnk_c, mux_hsync_c, mux_vsync_c;
    logic [RGB_W-1:0]  mux_rgb_c, scaled_c;
    logic [MUL_W-1:0]  prod_c;
    logic [SEL_W-1:0]  sel_n_c;
    logic              tick_c, step_c, leave_c;

    // Source select; the virtual source N_SRC borrows source 0 timing.
    always_comb begin
        mux_hcount_c = src_hcount[0 +: HC_W];
        mux_vcount_c = src_vcount[0 +: HC_W];
        mux_hblnk_c  = src_hblnk[0];
        mux_vblnk_c  = src_vblnk[0];
        mux_hsync_c  = src_hsync[0];
        mux_vsync_c  = src_vsync[0];
        mux_rgb_c    = DEFAULT_RGB;
        for (int i = 0; i < N_SRC; i++) begin
            if (active_src == SEL_W'(i)) begin
                mux_hcount_c = src_hcount[i*HC_W +: HC_W];
                mux_vcount_c = src_vcount[i*HC_W +: HC_W];
                mux_hblnk_c  = src_hblnk[i];
                mux_vblnk_c  = src_vblnk[i];
                mux_hsync_c  = src_hsync[i];
                mux_vsync_c  = src_vsync[i];
                mux_rgb_c    = src_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    // Per-channel brightness scaling of the stage-1 colour.
    always_comb begin
        scaled_c = '0;
        prod_c   = '0;
        for (int c = 0; c < CH_N; c++) begin
            prod_c = MUL_W'(s1_rgb[c*4 +: 4]) * MUL_W'(level);
            scaled_c[c*4 +: 4] = 4'(prod_c >> FADE_SHIFT);
        end
    end

    always_comb begin
        sel_n_c = (sel >= SEL_W'(N_SRC)) ? SEL_W'(N_SRC) : sel;
        leave_c = (sel_n_c != active_src);
        tick_c  = s1_vblnk & ~s1_vblnk_d;
        step_c  = tick_c & (step_cnt == CNT_LAST);
    end

    // Two-stage video pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hcount  <= '0;
            s1_vcount  <= '0;
            s1_hblnk   <= 1'b0;
            s1_vblnk   <= 1'b0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
            s1_rgb     <= '0;
            s1_vblnk_d <= 1'b0;
            out_hcount <= '0;
            out_vcount <= '0;
            out_hblnk  <= 1'b0;
            out_vblnk  <= 1'b0;
            out_hsync  <= 1'b0;
            out_vsync  <= 1'b0;
            out_rgb    <= '0;
        end else begin
            s1_hcount  <= mux_hcount_c;
            s1_vcount  <= mux_vcount_c;
            s1_hblnk   <= mux_hblnk_c;
            s1_vblnk   <= mux_vblnk_c;
            s1_hsync   <= mux_hsync_c;
            s1_vsync   <= mux_vsync_c;
            s1_rgb     <= mux_rgb_c;
            s1_vblnk_d <= s1_vblnk;
            out_hcount <= s1_hcount;
            out_vcount <= s1_vcount;
            out_hblnk  <= s1_hblnk;
            out_vblnk  <= s1_vblnk;
            out_hsync  <= s1_hsync;
            out_vsync  <= s1_vsync;
            out_rgb    <= (s1_hblnk | s1_vblnk) ? '0 : scaled_c;
        end
    end

    // Fade control: direction is settled by sel first, then any step moves the level that way.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= STEADY;
            active_src <= '0;
            pending    <= '0;
            level      <= FULL;
            step_cnt   <= '0;
            fading     <= 1'b0;
        end else begin
            if (state == STEADY)
                step_cnt <= '0;
            else if (tick_c)
                step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + CNT_W'(1);

            if (leave_c || state == FADE_OUT)
                pending <= sel_n_c;

            if (leave_c) begin
                if (state == FADE_OUT && step_c && level == '0) begin
                    active_src <= pending;
                    level      <= LVL_W'(1);
                    state      <= (FULL == LVL_W'(1)) ? STEADY : FADE_IN;
                    fading     <= (FULL != LVL_W'(1));
                end else begin
                    state  <= FADE_OUT;
                    fading <= 1'b1;
                    if (step_c && level != '0)
                        level <= level - LVL_W'(1);
                end
            end else if (state != STEADY) begin
                if (step_c && level >= FULL - LVL_W'(1)) begin
                    level  <= FULL;
                    state  <= STEADY;
                    fading <= 1'b0;
                end else begin
                    state  <= FADE_IN;
                    fading <= 1'b1;
                    if (step_c)
                        level <= level + LVL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_draw_fade_mux.sv
// Bench for draw_fade_mux: directed frame-level fade checks plus randomized
// cycle comparison against a behavioural model.
module tb_draw_fade_mux;

    localparam int unsigned N    = 6;
    localparam int unsigned HCW  = 11;
    localparam int unsigned RGBW = 12;
    localparam int unsigned SELW = 3;
    localparam int FS    = 2;
    localparam int FPS   = 1;
    localparam int FULL  = 4;
    localparam int H_TOT = 16;
    localparam int H_ACT = 10;
    localparam int V_TOT = 8;
    localparam int V_ACT = 5;
    localparam logic [RGBW-1:0] DEF = 12'h0F0;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [SELW-1:0]      sel;
    logic [N*HCW-1:0]     src_hcount, src_vcount;
    logic [N-1:0]         src_hblnk, src_vblnk, src_hsync, src_vsync;
    logic [N*RGBW-1:0]    src_rgb;
    logic [HCW-1:0]       out_hcount, out_vcount;
    logic                 out_hblnk, out_vblnk, out_hsync, out_vsync;
    logic [RGBW-1:0]      out_rgb;
    logic [SELW-1:0]      active_src;
    logic                 fading;

    draw_fade_mux #(
        .N_SRC(N), .HC_W(HCW), .RGB_W(RGBW), .FADE_SHIFT(FS),
        .FRAMES_PER_STEP(FPS), .DEFAULT_RGB(DEF)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel),
        .src_hcount(src_hcount), .src_vcount(src_vcount),
        .src_hblnk(src_hblnk), .src_vblnk(src_vblnk),
        .src_hsync(src_hsync), .src_vsync(src_vsync), .src_rgb(src_rgb),
        .out_hcount(out_hcount), .out_vcount(out_vcount),
        .out_hblnk(out_hblnk), .out_vblnk(out_vblnk),
        .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_rgb(out_rgb), .active_src(active_src), .fading(fading)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int hc = 0;
    int vc = 0;
    bit rand_rgb = 1'b0;
    logic [RGBW-1:0] rgb_v [N];

    // Model state: frame-level fade bookkeeping plus a two-deep video delay line.
    int m_level = FULL, m_active = 0, m_dir = 0, m_cnt = 0, m_prev_sel = 0;
    logic m_prev_vb = 1'b0;
    logic [HCW-1:0]  m1_hc = '0, m1_vc = '0, e_hc = '0, e_vc = '0;
    logic            m1_hb = 1'b0, m1_vb = 1'b0, m1_hs = 1'b0, m1_vs = 1'b0;
    logic            e_hb = 1'b0, e_vb = 1'b0, e_hs = 1'b0, e_vs = 1'b0;
    logic [RGBW-1:0] m1_rgb = '0, e_rgb = '0;

    function automatic logic [RGBW-1:0] scale(input logic [RGBW-1:0] c, input int lvl);
        int r, g, b;
        r = (int'(c[11:8]) * lvl) / FULL;
        g = (int'(c[7:4])  * lvl) / FULL;
        b = (int'(c[3:0])  * lvl) / FULL;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rand_rgb) rgb_v[i] = RGBW'($urandom);
            src_hcount[i*HCW +: HCW] = HCW'(hc + i*64);
            src_vcount[i*HCW +: HCW] = HCW'(vc + i*64);
            src_hblnk[i] = (hc >= H_ACT);
            src_vblnk[i] = (vc >= V_ACT);
            src_hsync[i] = (hc >= 12 && hc < 14);
            src_vsync[i] = (vc == 6);
            src_rgb[i*RGBW +: RGBW] = rgb_v[i];
        end
    endtask

    task automatic model_update();
        int sn, idx, ndir;
        bit tick, step;
        if (rst) begin
            {e_hc, e_vc, e_hb, e_vb, e_hs, e_vs, e_rgb} = '0;
            {m1_hc, m1_vc, m1_hb, m1_vb, m1_hs, m1_vs, m1_rgb} = '0;
            m_prev_vb = 1'b0; m_level = FULL; m_active = 0; m_dir = 0;
            m_cnt = 0; m_prev_sel = 0;
            return;
        end
        sn   = (int'(sel) >= N) ? N : int'(sel);
        tick = m1_vb && !m_prev_vb;
        step = tick && (m_cnt == FPS - 1);
        e_hc = m1_hc; e_vc = m1_vc; e_hb = m1_hb; e_vb = m1_vb; e_hs = m1_hs; e_vs = m1_vs;
        e_rgb = (m1_hb || m1_vb) ? '0 : scale(m1_rgb, m_level);
        m_prev_vb = m1_vb;
        idx   = (m_active == N) ? 0 : m_active;
        m1_hc = src_hcount[idx*HCW +: HCW];
        m1_vc = src_vcount[idx*HCW +: HCW];
        m1_hb = src_hblnk[idx]; m1_vb = src_vblnk[idx];
        m1_hs = src_hsync[idx]; m1_vs = src_vsync[idx];
        m1_rgb = (m_active == N) ? DEF : src_rgb[idx*RGBW +: RGBW];
        if (m_dir == 0) m_cnt = 0;
        else if (tick)  m_cnt = (m_cnt + 1) % FPS;
        if (sn != m_active) ndir = -1;
        else ndir = (m_dir == 0) ? 0 : 1;
        if (step) begin
            if (ndir == -1 && m_dir == -1 && m_level == 0) begin
                m_active = m_prev_sel;
                m_level  = 1;
                ndir     = (FULL == 1) ? 0 : 1;
            end else if (ndir == -1) begin
                m_level = (m_level > 0) ? m_level - 1 : 0;
            end else if (ndir == 1) begin
                m_level = m_level + 1;
                if (m_level >= FULL) begin m_level = FULL; ndir = 0; end
            end
        end
        m_dir = ndir;
        m_prev_sel = sn;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_update();
        #1;
        hc = hc + 1;
        if (hc == H_TOT) begin hc = 0; vc = (vc + 1) % V_TOT; end
        drive();
    endtask

    task automatic goto_pos(input int h, input int v);
        for (int n = 0; n < 2*H_TOT*V_TOT; n++) begin
            clk_step();
            if (hc == h && vc == v) break;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) rgb_v[i] = RGBW'(12'h5A3 + i*12'h111);
        rand_rgb = 1'b0; sel = '0; rst = 1'b0;
        drive();
        goto_pos(2, 1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clk_step();
            n_cmp++;
            if ({out_hcount, out_vcount, out_hblnk, out_vblnk, out_hsync, out_vsync,
                 out_rgb, active_src, fading} !== '0) begin
                n_bad++;
                $display("FAIL reset_state cyc %0d: rgb=%h hc=%0d act=%0d fading=%b, want all zero",
                         k, out_rgb, out_hcount, active_src, fading);
            end
        end
        rst = 1'b0;
        clk_step();
        n_cmp++;
        if (out_rgb !== '0) begin
            n_bad++; $display("FAIL reset_stage2_empty: out_rgb=%h want 000", out_rgb);
        end
        clk_step();
        n_cmp++;
        if (out_rgb !== rgb_v[0] || out_hcount !== HCW'(5)) begin
            n_bad++;
            $display("FAIL reset_first_pixel: out_rgb=%h hc=%0d want %h hc=5", out_rgb, out_hcount, rgb_v[0]);
        end
    endtask

    task automatic test_passthrough();
        int p1h, p1v, p2h, p2v;
        logic [RGBW-1:0] want;
        rgb_v[0] = 12'hABC;
        drive();
        p1h = hc; p1v = vc; p2h = 0; p2v = 0;
        for (int k = 0; k < 2*H_TOT*V_TOT; k++) begin
            p2h = p1h; p2v = p1v; p1h = hc; p1v = vc;
            clk_step();
            if (k < 2) continue;
            want = (p2h >= H_ACT || p2v >= V_ACT) ? 12'h000 : 12'hABC;
            n_cmp++;
            if (out_rgb !== want || out_hcount !== HCW'(p2h) || out_vcount !== HCW'(p2v)) begin
                n_bad++;
                $display("FAIL passthrough k=%0d: rgb=%h hc=%0d vc=%0d want rgb=%h hc=%0d vc=%0d",
                         k, out_rgb, out_hcount, out_vcount, want, p2h, p2v);
            end
        end
    endtask

    task automatic test_reversal();
        logic [RGBW-1:0] want [5];
        want[0] = 12'hFFF; want[1] = 12'hBBB; want[2] = 12'h777;
        want[3] = 12'hBBB; want[4] = 12'hFFF;
        rgb_v[0] = 12'hFFF; rgb_v[3] = 12'h888;
        drive();
        goto_pos(0, 2);
        sel = 3'd3;
        for (int f = 0; f < 5; f++) begin
            if (f == 2) begin goto_pos(0, 2); sel = 3'd0; end
            goto_pos(5, 2);
            n_cmp++;
            if (out_rgb !== want[f] || active_src !== 3'd0 || fading !== (f < 4)) begin
                n_bad++;
                $display("FAIL reversal frame %0d: rgb=%h act=%0d fading=%b want rgb=%h act=0 fading=%b",
                         f, out_rgb, active_src, fading, want[f], (f < 4));
            end
        end
    endtask

    task automatic test_fade_sequence();
        logic [RGBW-1:0] want [9];
        logic [SELW-1:0] want_act;
        want[0] = 12'hFFF; want[1] = 12'hBBB; want[2] = 12'h777; want[3] = 12'h333;
        want[4] = 12'h000; want[5] = 12'h222; want[6] = 12'h444; want[7] = 12'h666;
        want[8] = 12'h888;
        goto_pos(0, 2);
        sel = 3'd3;
        for (int f = 0; f < 9; f++) begin
            goto_pos(5, 2);
            want_act = (f < 5) ? 3'd0 : 3'd3;
            n_cmp++;
            if (out_rgb !== want[f] || active_src !== want_act || fading !== (f < 8)) begin
                n_bad++;
                $display("FAIL fade_seq frame %0d: rgb=%h act=%0d fading=%b want rgb=%h act=%0d fading=%b",
                         f, out_rgb, active_src, fading, want[f], want_act, (f < 8));
            end
            if (f == 5) begin
                n_cmp++;
                if (out_hcount !== HCW'(3 + 3*64)) begin
                    n_bad++; $display("FAIL fade_seq_timing: out_hcount=%0d want %0d", out_hcount, 3 + 3*64);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        goto_pos(0, 2);
        sel = 3'd6;
        for (int f = 0; f < 9; f++) begin
            goto_pos(5, 2);
            if (f == 5) begin
                n_cmp++;
                if (out_rgb !== 12'h030 || active_src !== 3'd6) begin
                    n_bad++; $display("FAIL oor_fade_in: rgb=%h act=%0d want 030 act=6", out_rgb, active_src);
                end
            end
        end
        n_cmp++;
        if (out_rgb !== DEF || active_src !== 3'd6 || fading !== 1'b0 ||
            out_hcount !== HCW'(3) || out_vcount !== HCW'(2)) begin
            n_bad++;
            $display("FAIL oor_steady: rgb=%h act=%0d fading=%b hc=%0d vc=%0d want 0f0 act=6 fading=0 hc=3 vc=2",
                     out_rgb, active_src, fading, out_hcount, out_vcount);
        end
    endtask

    task automatic test_reset_mid_fade();
        goto_pos(0, 2);
        sel = 3'd3;
        for (int f = 0; f < 6; f++) goto_pos(5, 2);
        n_cmp++;
        if (out_rgb !== 12'h222 || active_src !== 3'd3 || fading !== 1'b1) begin
            n_bad++; $display("FAIL midfade_pre: rgb=%h act=%0d fading=%b want 222 act=3 fading=1",
                              out_rgb, active_src, fading);
        end
        rst = 1'b1; sel = 3'd0;
        clk_step(); clk_step();
        n_cmp++;
        if (active_src !== 3'd0 || fading !== 1'b0 || out_rgb !== '0) begin
            n_bad++; $display("FAIL midfade_reset: act=%0d fading=%b rgb=%h want act=0 fading=0 rgb=000",
                              active_src, fading, out_rgb);
        end
        rst = 1'b0;
        goto_pos(5, 2);
        n_cmp++;
        if (out_rgb !== 12'hFFF || active_src !== 3'd0 || fading !== 1'b0 || out_hcount !== HCW'(3)) begin
            n_bad++; $display("FAIL midfade_after: rgb=%h act=%0d fading=%b hc=%0d want FFF act=0 fading=0 hc=3",
                              out_rgb, active_src, fading, out_hcount);
        end
    endtask

    task automatic test_random(input int cycles, input int max_gap);
        int gap;
        logic [41:0] got, want;
        rand_rgb = 1'b1;
        gap = 1;
        for (int k = 0; k < cycles; k++) begin
            gap--;
            if (gap <= 0) begin
                sel = SELW'($urandom_range(0, N));
                gap = int'($urandom_range(1, max_gap));
            end
            clk_step();
            got  = {out_hcount, out_vcount, out_hblnk, out_vblnk, out_hsync, out_vsync,
                    out_rgb, active_src, fading};
            want = {e_hc, e_vc, e_hb, e_vb, e_hs, e_vs, e_rgb, SELW'(m_active), (m_dir != 0)};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random k=%0d gap=%0d: got %h want %h", k, max_gap, got, want);
            end
        end
        rand_rgb = 1'b0;
    endtask

    task automatic test_back_to_back();
        test_random(600, 6);
    endtask

    initial begin
        rst = 1'b1; sel = '0;
        for (int i = 0; i < N; i++) rgb_v[i] = '0;
        drive();
        repeat (4) clk_step();
        test_reset();
        test_passthrough();
        test_reversal();
        test_fade_sequence();
        test_out_of_range();
        test_reset_mid_fade();
        test_random(3000, 400);
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
